msg_bit_fifo: RTL and testbench

Upstream feeder for the 18-bit, weight-9 constant-weight encoder. Accepts parallel message words over a valid/ready handshake and buffers them in a small ring of words. Serves the bits MSB-first over the encoder's 1-bit FIFO port (`readfifo` / `bin_msg` / `fifoempty`). A read request returns its bit on the following clock edge, matching the encoder's two-cycle fetch-then-test pattern and its back-to-back reads during bit-string decoding.

---
 rtl/cwc_pkg.sv | 14 +
 rtl/msg_bit_fifo.sv | 135 +++++++++++++
 tb/tb_msg_bit_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cwc_pkg.sv
// Shared constants for the constant-weight codeword (CWC) encoder path.
// Holds the default message-buffer geometry used by msg_bit_fifo and the
// encoder's codeword length/weight, which the bench and the top level share.
package cwc_pkg;

  // Default message word width and buffer depth for msg_bit_fifo.
  localparam int CWC_MSG_W     = 16;
  localparam int CWC_BUF_DEPTH = 4;

  // Encoder codeword length and weight (18-bit, weight-9 code).
  localparam int CWC_N = 18;
  localparam int CWC_T = 9;

endpackage : cwc_pkg

// File: rtl/msg_bit_fifo.sv
// msg_bit_fifo: word-in / bit-out feeder for the constant-weight encoder.
// Parallel message words are buffered in a small ring and served MSB-first,
// one bit per accepted read, with the bit registered on the edge that accepts
// the read.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous active-low reset
//   flush      in   synchronous clear of all buffered data (wins over rd/wr)
//   in_word    in   message word, bit MSG_W-1 sent first
//   in_valid   in   in_word is valid
//   in_ready   out  buffer can accept a word this cycle
//   readfifo   in   request the next bit
//   bin_msg    out  registered bit returned by the last accepted read
//   fifoempty  out  no unread bits remain
//   bits_avail out  count of unread bits
module msg_bit_fifo
  import cwc_pkg::*;
#(
  parameter int MSG_W = CWC_MSG_W,
  parameter int DEPTH = CWC_BUF_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               flush,
  input  logic [MSG_W-1:0]                   in_word,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               readfifo,
  output logic                               bin_msg,
  output logic                               fifoempty,
  output logic [$clog2(DEPTH*MSG_W+1)-1:0]   bits_avail
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(MSG_W);
  localparam int AV_W  = $clog2(DEPTH * MSG_W + 1);

  logic [MSG_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] wcount_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic             bin_msg_r;

  logic             in_ready_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic             last_bit_s;
  logic             retire_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [MSG_W-1:0] head_word_s;
  logic             head_bit_s;
  logic [CNT_W-1:0] wcount_nxt_s;

  // Status derived only from registered state, so a full buffer refuses a
  // write even when a retire frees a slot in the same cycle.
  assign in_ready_s = (wcount_r != CNT_W'(DEPTH));
  assign empty_s    = (wcount_r == CNT_W'(0));

  assign in_ready   = in_ready_s;
  assign fifoempty  = empty_s;
  assign bin_msg    = bin_msg_r;
  assign bits_avail = AV_W'(wcount_r) * AV_W'(MSG_W) - AV_W'(bit_idx_r);

  // Handshake qualification and head-bit selection (MSB first).
  always_comb begin
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    if (flush) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = in_valid && in_ready_s;
      rd_en_s = readfifo && !empty_s;
    end
    last_bit_s  = (bit_idx_r == IDX_W'(MSG_W - 1));
    retire_s    = rd_en_s && last_bit_s;
    sel_idx_s   = IDX_W'(MSG_W - 1) - bit_idx_r;
    head_word_s = mem_r[rd_ptr_r];
    head_bit_s  = head_word_s[sel_idx_s];
  end

  // Word count: a write and a retire in the same cycle cancel out.
  always_comb begin
    wcount_nxt_s = wcount_r;
    case ({wr_en_s, retire_s})
      2'b10:   wcount_nxt_s = wcount_r + CNT_W'(1);
      2'b01:   wcount_nxt_s = wcount_r - CNT_W'(1);
      default: wcount_nxt_s = wcount_r;
    endcase
  end

  // Word storage; contents are never reset because unread state lives in
  // the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_word;
    end
  end

  // Pointer, count, bit offset and output-bit registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_r  <= PTR_W'(0);
      rd_ptr_r  <= PTR_W'(0);
      wcount_r  <= CNT_W'(0);
      bit_idx_r <= IDX_W'(0);
      bin_msg_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r  <= PTR_W'(0);
      rd_ptr_r  <= PTR_W'(0);
      wcount_r  <= CNT_W'(0);
      bit_idx_r <= IDX_W'(0);
      bin_msg_r <= 1'b0;
    end else begin
      wcount_r <= wcount_nxt_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        bin_msg_r <= head_bit_s;
        if (last_bit_s) begin
          bit_idx_r <= IDX_W'(0);
          rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
        end else begin
          bit_idx_r <= bit_idx_r + IDX_W'(1);
        end
      end
    end
  end

endmodule : msg_bit_fifo

// File: tb/tb_msg_bit_fifo.sv
// Self-checking bench for msg_bit_fifo. Expected bits are pushed to a queue
// (MSB first) when a word is accepted and popped when a read is accepted;
// the count and status outputs are derived from the queue length.
module tb_msg_bit_fifo;
  import cwc_pkg::*;

  localparam int MSG_W = CWC_MSG_W;
  localparam int DEPTH = CWC_BUF_DEPTH;
  localparam int AV_W  = $clog2(DEPTH * MSG_W + 1);

  logic             clk;
  logic             rst_b;
  logic             flush;
  logic [MSG_W-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic             readfifo;
  logic             bin_msg;
  logic             fifoempty;
  logic [AV_W-1:0]  bits_avail;

  int errors = 0;
  int checks = 0;

  bit q[$];
  bit m_last;

  msg_bit_fifo #(.MSG_W(MSG_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .flush      (flush),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .readfifo   (readfifo),
    .bin_msg    (bin_msg),
    .fifoempty  (fifoempty),
    .bits_avail (bits_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_words();
    return (q.size() + MSG_W - 1) / MSG_W;
  endfunction

  task automatic check_status();
    check_eq("bin_msg", 32'(bin_msg), 32'(m_last));
    check_eq("bits_avail", 32'(bits_avail), 32'(q.size()));
    check_eq("fifoempty", 32'(fifoempty), 32'(model_words() == 0));
    check_eq("in_ready", 32'(in_ready), 32'(model_words() != DEPTH));
  endtask

  // One clock: drive inputs, predict acceptance from pre-edge model state,
  // then update the scoreboard and compare after the edge.
  task automatic cycle(input logic v, input logic [MSG_W-1:0] w, input logic rd, input logic fl);
    logic wr_acc, rd_acc;
    int   wc;
    wc       = model_words();
    in_valid = v;
    in_word  = w;
    readfifo = rd;
    flush    = fl;
    wr_acc   = v && (wc != DEPTH) && !fl;
    rd_acc   = rd && (wc != 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      m_last = 1'b0;
    end else begin
      if (rd_acc) m_last = q.pop_front();
      if (wr_acc) for (int i = MSG_W - 1; i >= 0; i--) q.push_back(w[i]);
    end
    check_status();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH * MSG_W + 2; i++) begin
      if (q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  // Assert reset mid-cycle and check outputs before any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    q.delete();
    m_last = 1'b0;
    check_eq("rst_fifoempty", 32'(fifoempty), 32'd1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_bin_msg", 32'(bin_msg), 32'd0);
    check_eq("rst_bits_avail", 32'(bits_avail), 32'd0);
    in_valid = 1'b0;
    readfifo = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #2;
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b    = 1'b0;
    flush    = 1'b0;
    in_word  = '0;
    in_valid = 1'b0;
    readfifo = 1'b0;
    m_last   = 1'b0;
    #2;
    check_eq("init_fifoempty", 32'(fifoempty), 32'd1);
    check_eq("init_in_ready", 32'(in_ready), 32'd1);
    check_eq("init_bin_msg", 32'(bin_msg), 32'd0);
    check_eq("init_bits_avail", 32'(bits_avail), 32'd0);
    #10;
    rst_b = 1'b1;

    // Single word serialisation.
    cycle(1'b1, 16'hA5C3, 1'b0, 1'b0);
    check_eq("one_word_avail", 32'(bits_avail), 32'd16);
    for (int i = 0; i < MSG_W; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("one_word_empty", 32'(fifoempty), 32'd1);

    // Read while empty after a last bit of 1: output holds.
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("empty_read_hold", 32'(bin_msg), 32'd1);

    // Fill to full, hold a 5th word under backpressure, then drain.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, MSG_W'(i), 1'b0, 1'b0);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h0005, 1'b0, 1'b0);
    check_eq("full_refused", 32'(bits_avail), 32'd64);
    for (int i = 0; i < MSG_W; i++) cycle(1'b1, 16'h0005, 1'b1, 1'b0);
    check_eq("full_ready_again", 32'(in_ready), 32'd1);
    cycle(1'b1, 16'h0005, 1'b0, 1'b0);
    check_eq("fifth_accepted", 32'(bits_avail), 32'd64);
    in_valid = 1'b0;
    drain();

    // Simultaneous write and retire with two words and bit_idx = 15.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    cycle(1'b1, 16'hF00F, 1'b0, 1'b0);
    for (int i = 0; i < MSG_W - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'h8E71, 1'b1, 1'b0);
    check_eq("sim_wr_retire", 32'(bits_avail), 32'd32);
    drain();

    // Flush with a concurrent write: word dropped, buffer cleared.
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
    check_eq("flush_avail", 32'(bits_avail), 32'd0);
    check_eq("flush_empty", 32'(fifoempty), 32'd1);
    cycle(1'b1, 16'h8001, 1'b0, 1'b0);
    drain();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), MSG_W'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));
    end

    // Mid-word asynchronous reset with data buffered.
    cycle(1'b1, 16'hC3C3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    async_reset();
    cycle(1'b1, 16'h6A5F, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_msg_bit_fifo
